autosym_sweep_ctrl: RTL and testbench
=====================================

Name: autosym_sweep_ctrl

Overview:
- Sequencer that exhaustively drives the 10-bit input vector x0..x9 of an external combinational benchmark function and samples its single output y0.
- Records the full truth table and counts the on-set.
- Then checks whether the function is autosymmetric under a caller-supplied translation vector alpha, i.e. f(x) == f(x ^ alpha) for all x.
- Sits between the optimized benchmark netlist and the experiment harness, so every optimized PLA netlist can be characterized in hardware.

Parameters:
- N, 10, input width of the function under test; the table holds 2^N entries.
- SETTLE, 1, extra hold cycles per vector before y0 is sampled; 0 means sample in the same cycle the vector is driven.

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a new run; accepted only in IDLE
- alpha  in  N  translation vector; latched when start is accepted
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when results are valid
- x_drv  out  N  vector driven to the function under test (bit i -> xi)
- y_in  in  1  y0 returned by the function under test
- onset_count  out  N+1  number of x with f(x)=1
- is_symmetric  out  1  1 if f(x)==f(x^alpha) for all x
- mismatch_x  out  N  lowest x with f(x)!=f(x^alpha); 0 when symmetric

Behaviour:
- Reset: state=IDLE; busy=0, done=0, x_drv=0, onset_count=0, is_symmetric=0, mismatch_x=0; index, hold counter, latched alpha and table cleared.
- IDLE -> SWEEP on start=1:
  - latch alpha; clear onset_count, is_symmetric, mismatch_x and the index.
- SWEEP:
  - x_drv=index, held for SETTLE+1 cycles.
  - On the last hold cycle: table[index]<=y_in; onset_count += y_in.
  - Index increments after each sample.
  - After sampling index 2^N-1: go to CHECK with index=0; x_drv returns to 0.
- CHECK, one x per cycle:
  - compare table[index] with table[index^alpha].
  - On mismatch: mismatch_x<=index, is_symmetric<=0, go to FIN.
  - If index==2^N-1 with no mismatch: is_symmetric<=1, go to FIN.
  - Otherwise index++.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- Results hold until the next accepted start.
- Latency, full run: done is high in cycle A + 2^N*(SETTLE+1) + 2^N + 1, where A is the accept edge. For N=10, SETTLE=1 this is A+3073.
- Early exit: a mismatch at index m shortens CHECK to m+1 cycles.
- start while busy: ignored, no effect on the run in progress.
- start in the FIN cycle: ignored. start in the first IDLE cycle after FIN: accepted.
- alpha changes while busy: ignored; the latched value is used.
- alpha=0: always symmetric.
- onset_count width N+1, so a constant-1 function reports 2^N with no overflow.
- Index wraps only through state exit; it never wraps inside SWEEP or CHECK.
- rst_n low mid-run: immediate return to reset values; no done pulse; the next run starts from a clean table.

Decomposition:
- Shared package autosym_pkg holds:
  - N_DEFAULT constant
  - state enum {IDLE, SWEEP, CHECK, FIN}
  - result struct {onset_count, is_symmetric, mismatch_x}
- Sub-module truth_table_mem, 2^N x 1 flop array:
  - one synchronous write port
  - two combinational read ports, addresses index and index^alpha

Test Plan:
- Stub y=x0^x1, alpha=0x003, start -> done at A+3073, onset_count=512, is_symmetric=1, mismatch_x=0.
- Same stub, alpha=0x001 -> is_symmetric=0, mismatch_x=0x000, done at A+2048+1+1.
- Stub y=x9&x8, alpha=0x100 -> onset_count=256, is_symmetric=0, mismatch_x=0x200.
- Stub y=0, alpha=0x3FF; then stub y=1, alpha=0 -> first run onset_count=0, is_symmetric=1; second run onset_count=1024, is_symmetric=1.
- Pulse start and change alpha at A+100 -> no restart, latched alpha used, exactly one done pulse.
- Assert rst_n=0 at A+500 mid-SWEEP -> all outputs 0 at once, no done; a fresh run then gives the correct results.
- All directed runs (SETTLE=1 unless overridden): check x_drv is held SETTLE+1 cycles per vector; also run with SETTLE=0 -> done at A+2049.

Source files
------------

// File: rtl/autosym_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | autosym_pkg : shared types for the autosymmetry sweep controller     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package autosym_pkg;

    localparam int N_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic [N_DEFAULT:0]   onset_count;
        logic                 is_symmetric;
        logic [N_DEFAULT-1:0] mismatch_x;
    } result_t;

endpackage
`default_nettype wire

// File: rtl/truth_table_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | truth_table_mem : 2^N x 1 flop array, 1 sync write, 2 comb reads     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module truth_table_mem
    import autosym_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [N-1:0] waddr,
    input  logic         wdata,
    input  logic [N-1:0] raddr_a,
    input  logic [N-1:0] raddr_b,
    output logic         rdata_a,
    output logic         rdata_b
);

    localparam int c_depth = 1 << N;

    logic [c_depth-1:0] r_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bits <= '0;
        end else if (we) begin
            r_bits[waddr] <= wdata;
        end
    end

    assign rdata_a = r_bits[raddr_a];
    assign rdata_b = r_bits[raddr_b];

endmodule
`default_nettype wire

// File: rtl/autosym_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | autosym_sweep_ctrl : sweeps f(x), records truth table, tests f(x^a)  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module autosym_sweep_ctrl
    import autosym_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] alpha,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] x_drv,
    input  logic         y_in,
    output logic [N:0]   onset_count,
    output logic         is_symmetric,
    output logic [N-1:0] mismatch_x
);

    localparam int                c_hold_w     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last  = c_hold_w'(SETTLE);
    localparam logic [N-1:0]      c_index_last = '1;

    state_t              r_state;
    logic [N-1:0]        r_index;
    logic [N-1:0]        r_alpha;
    logic [c_hold_w-1:0] r_hold;
    logic                w_sample;
    logic                w_rd_a;
    logic                w_rd_b;

    // y_in is captured only on the final hold cycle of each vector
    assign w_sample = (r_state == SWEEP) && (r_hold == c_hold_last);

    truth_table_mem #(.N(N)) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (w_sample),
        .waddr   (r_index),
        .wdata   (y_in),
        .raddr_a (r_index),
        .raddr_b (r_index ^ r_alpha),
        .rdata_a (w_rd_a),
        .rdata_b (w_rd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_index      <= '0;
            r_alpha      <= '0;
            r_hold       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            x_drv        <= '0;
            onset_count  <= '0;
            is_symmetric <= 1'b0;
            mismatch_x   <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state      <= SWEEP;
                        r_alpha      <= alpha;
                        r_index      <= '0;
                        r_hold       <= '0;
                        busy         <= 1'b1;
                        x_drv        <= '0;
                        onset_count  <= '0;
                        is_symmetric <= 1'b0;
                        mismatch_x   <= '0;
                    end
                end
                SWEEP: begin
                    if (w_sample) begin
                        onset_count <= onset_count + {{N{1'b0}}, y_in};
                        r_hold      <= '0;
                        if (r_index == c_index_last) begin
                            r_state <= CHECK;
                            r_index <= '0;
                            x_drv   <= '0;
                        end else begin
                            r_index <= r_index + 1'b1;
                            x_drv   <= r_index + 1'b1;
                        end
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                CHECK: begin
                    // ascending scan, so the first mismatch is the lowest x
                    if (w_rd_a != w_rd_b) begin
                        mismatch_x   <= r_index;
                        is_symmetric <= 1'b0;
                        r_state      <= FIN;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                    end else if (r_index == c_index_last) begin
                        is_symmetric <= 1'b1;
                        r_state      <= FIN;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        r_index <= r_index + 1'b1;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_index <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_autosym_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_autosym_sweep_ctrl : directed table + random runs vs truth model  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_autosym_sweep_ctrl;
    import autosym_pkg::*;

    localparam int N     = N_DEFAULT;
    localparam int DEPTH = 1 << N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start;
    logic         cur;      // 0: SETTLE=1 instance, 1: SETTLE=0 instance
    logic [N-1:0] alpha;
    logic         tt [DEPTH];

    logic         busy1, done1, sym1, y1;
    logic [N-1:0] x1, mis1;
    logic [N:0]   on1;
    logic         busy0, done0, sym0, y0;
    logic [N-1:0] x0, mis0;
    logic [N:0]   on0;

    assign y1 = tt[x1];
    assign y0 = tt[x0];

    autosym_sweep_ctrl #(.N(N), .SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start & ~cur), .alpha(alpha),
        .busy(busy1), .done(done1), .x_drv(x1), .y_in(y1),
        .onset_count(on1), .is_symmetric(sym1), .mismatch_x(mis1)
    );

    autosym_sweep_ctrl #(.N(N), .SETTLE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start & cur), .alpha(alpha),
        .busy(busy0), .done(done0), .x_drv(x0), .y_in(y0),
        .onset_count(on0), .is_symmetric(sym0), .mismatch_x(mis0)
    );

    logic         m_busy, m_done, m_sym;
    logic [N-1:0] m_x, m_mis;
    logic [N:0]   m_on;
    assign m_busy = cur ? busy0 : busy1;
    assign m_done = cur ? done0 : done1;
    assign m_sym  = cur ? sym0  : sym1;
    assign m_x    = cur ? x0    : x1;
    assign m_mis  = cur ? mis0  : mis1;
    assign m_on   = cur ? on0   : on1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain truth-table arithmetic over the stub's table
    function automatic result_t ref_model(input logic [N-1:0] a);
        result_t r;
        r = '0;
        r.is_symmetric = 1'b1;
        for (int x = 0; x < DEPTH; x++)
            r.onset_count = r.onset_count + {{N{1'b0}}, tt[x]};
        for (int x = DEPTH - 1; x >= 0; x--) begin
            if (tt[x] != tt[x ^ int'(a)]) begin
                r.is_symmetric = 1'b0;
                r.mismatch_x   = N'(x);
            end
        end
        return r;
    endfunction

    function automatic int ref_latency(input result_t r, input int settle);
        return DEPTH * (settle + 1) + (r.is_symmetric ? DEPTH : int'(r.mismatch_x) + 1) + 1;
    endfunction

    task automatic fill_func(input int f);
        logic [N-1:0] xv;
        for (int x = 0; x < DEPTH; x++) begin
            xv = N'(x);
            case (f)
                0:       tt[x] = xv[0] ^ xv[1];
                1:       tt[x] = xv[9] & xv[8];
                2:       tt[x] = 1'b0;
                default: tt[x] = 1'b1;
            endcase
        end
    endtask

    task automatic start_run(input logic [N-1:0] a, input logic s0);
        @(negedge clk);
        cur   = s0;
        alpha = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called at cycle A+1; follows the run up to the done cycle.
    task automatic track(input int max_cyc, input int glitch_at, input int settle,
                         output int lat, output int bad, output int changes);
        int           cyc;
        int           holdlen;
        logic [N-1:0] prev;
        cyc = 1; bad = 0; changes = 0; holdlen = 1; prev = m_x; lat = -1;
        if (!m_busy) bad++;
        while (!m_done && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == glitch_at) begin
                start = 1'b1;
                alpha = alpha ^ 10'h002;
            end else begin
                start = 1'b0;
            end
            if (!m_done) begin
                if (!m_busy) bad++;
                if (m_x == prev) begin
                    holdlen++;
                end else begin
                    changes++;
                    if (holdlen != settle + 1 || m_x != prev + 1'b1) bad++;
                    prev    = m_x;
                    holdlen = 1;
                end
            end
        end
        start = 1'b0;
        if (m_done) lat = cyc;
    endtask

    task automatic finish_run(input string nm, input int e_on, input logic e_sym,
                              input int e_mis, input int e_lat, input int glitch_at,
                              input logic fin_start);
        int lat, bad, changes;
        track(e_lat + 20, glitch_at, cur ? 0 : 1, lat, bad, changes);
        chk({nm, " latency"}, lat, e_lat);
        chk({nm, " hold/busy"}, bad, 0);
        chk({nm, " vectors"}, changes, DEPTH);
        chk({nm, " onset"}, m_on, e_on);
        chk({nm, " symmetric"}, m_sym, e_sym);
        chk({nm, " mismatch_x"}, m_mis, e_mis);
        chk({nm, " busy at done"}, m_busy, 0);
        if (fin_start) start = 1'b1;
        @(posedge clk);
        #1;
        chk({nm, " after done"}, {m_done, m_busy}, 0);
        if (!fin_start) begin
            repeat (3) @(posedge clk);
            #1;
            chk({nm, " results hold"}, {m_on, m_sym, m_mis, m_busy}, {e_on[N:0], e_sym, e_mis[N-1:0], 1'b0});
        end
    endtask

    typedef struct {
        int           func;
        logic [N-1:0] a;
        logic         s0;
        int           e_on;
        logic         e_sym;
        int           e_mis;
        int           e_lat;
    } vec_t;

    vec_t         vt [6];
    result_t      exp_r;
    logic [N-1:0] ra;

    initial begin
        vt[0] = '{0, 10'h003, 1'b0, 512,  1'b1, 0,     3073};
        vt[1] = '{0, 10'h001, 1'b0, 512,  1'b0, 0,     2050};
        vt[2] = '{1, 10'h100, 1'b0, 256,  1'b0, 'h200, 2562};
        vt[3] = '{2, 10'h3FF, 1'b0, 0,    1'b1, 0,     3073};
        vt[4] = '{3, 10'h000, 1'b0, 1024, 1'b1, 0,     3073};
        vt[5] = '{0, 10'h003, 1'b1, 512,  1'b1, 0,     2049};

        rst_n = 1'b0; start = 1'b0; cur = 1'b0; alpha = '0;
        fill_func(3);
        repeat (3) @(posedge clk);
        #1;
        chk("reset s1", {busy1, done1, x1, on1, sym1, mis1}, 0);
        chk("reset s0", {busy0, done0, x0, on0, sym0, mis0}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            fill_func(vt[i].func);
            start_run(vt[i].a, vt[i].s0);
            finish_run($sformatf("vec%0d", i), vt[i].e_on, vt[i].e_sym, vt[i].e_mis,
                       vt[i].e_lat, 0, 1'b0);
        end

        // start and alpha change mid-run must not disturb the latched run
        fill_func(0);
        start_run(10'h003, 1'b0);
        finish_run("glitch", 512, 1'b1, 0, 3073, 100, 1'b0);

        // start in FIN ignored, start in the following IDLE cycle accepted
        start_run(10'h001, 1'b0);
        finish_run("fin_a", 512, 1'b0, 0, 2050, 0, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("fin idle accept", m_busy, 1);
        finish_run("fin_b", 512, 1'b0, 0, 2050, 0, 1'b0);

        // asynchronous reset mid-sweep
        start_run(10'h003, 1'b0);
        repeat (499) @(posedge clk);
        #1;
        chk("pre-reset busy", m_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid reset outputs", {busy1, done1, x1, on1, sym1, mis1}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset no done", {done1, busy1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_func(1);
        start_run(10'h100, 1'b0);
        finish_run("post-reset", 256, 1'b0, 'h200, 2562, 0, 1'b0);

        // random functions: arbitrary, alpha-symmetric, symmetric with one flip
        for (int r = 0; r < 6; r++) begin
            ra = N'($urandom);
            for (int x = 0; x < DEPTH; x++) tt[x] = 1'($urandom_range(0, 1));
            if (r % 3 != 0) begin
                for (int x = 0; x < DEPTH; x++)
                    if ((x ^ int'(ra)) < x) tt[x] = tt[x ^ int'(ra)];
            end
            if (r % 3 == 2) begin
                int p;
                p = $urandom_range(0, DEPTH - 1);
                tt[p] = ~tt[p];
            end
            exp_r = ref_model(ra);
            start_run(ra, (r >= 4) ? 1'b1 : 1'b0);
            finish_run($sformatf("rand%0d", r), int'(exp_r.onset_count), exp_r.is_symmetric,
                       int'(exp_r.mismatch_x), ref_latency(exp_r, (r >= 4) ? 0 : 1), 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
